fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning queue capacity in 32-bit instructions (power of two, at least 4).
REQ-002 SHALL have parameter ISSUE_W, default 2, meaning maximum instructions presented and dequeued per cycle (1 or 2).
REQ-003 SHALL have parameter RESET_PC, default 64'h0, meaning first fetch address after reset.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 flush  in  1  discard all queued and in-flight instructions; restart at redirect_pc.
REQ-007 redirect_pc  in  64  new fetch byte address; bits [62:63] are zero.
REQ-008 fetch_req  out  1  request one 64-bit doubleword from memory.
REQ-009 fetch_addr  out  61  doubleword address, equal to fetch pc[0:60].
REQ-010 fetch_valid  in  1  memory response strobe for the single outstanding request.
REQ-011 fetch_data  in  64  response; [0:31] is the lower-address instruction, [32:63] the upper.
REQ-012 out_valid  out  ISSUE_W  per-slot valid; slot 0 is the oldest instruction.
REQ-013 out_insn  out  32*ISSUE_W  instructions from the queue head, slot 0 first.
REQ-014 out_pc  out  64*ISSUE_W  byte address of each presented instruction.
REQ-015 deq_count  in  2  number of slots consumed this cycle (0..ISSUE_W).
REQ-016 count  out  log2(DEPTH)+1  current occupancy.

Function
REQ-017 SHALL be a circular buffer with head and tail pointers of log2(DEPTH) bits, wrapping modulo DEPTH, plus a separate occupancy counter.
REQ-018 SHALL implement FSM states IDLE (no request outstanding), WAIT (request outstanding), and DROP (request outstanding but flushed).
REQ-019 In IDLE, SHALL assert fetch_req for one cycle and enter WAIT when free slots are at least 2 and flush is low.
REQ-020 SHALL allow at most one request outstanding; fetch_req SHALL stay low in WAIT and DROP.
REQ-021 In WAIT, on fetch_valid SHALL push both words and add 8 to the fetch pc; when fetch pc[61] is 1, SHALL push only [32:63] and add 4; SHALL then return to IDLE.
REQ-022 The pushed instructions SHALL appear on out_* in the cycle after fetch_valid; there is no same-cycle bypass.
REQ-023 out_valid[i] SHALL be 1 when count exceeds i; out_pc SHALL be the recorded pc of each entry.
REQ-024 A deq_count larger than the number of valid slots SHALL be clamped to that number.
REQ-025 A push and a dequeue in the same cycle SHALL both take effect: count_next = count + pushed - popped.
REQ-026 On flush, SHALL zero count, set head equal to tail, and load the fetch pc from redirect_pc; in that cycle flush SHALL override push and dequeue.
REQ-027 A flush in WAIT SHALL move the FSM to DROP; the next fetch_valid SHALL be discarded and the FSM SHALL go to IDLE.
REQ-028 A flush in DROP SHALL remain in DROP and update only the fetch pc.
REQ-029 fetch_valid outside WAIT and DROP SHALL be ignored.
REQ-030 When full, or when fewer than 2 slots are free, SHALL issue no request; the queue SHALL never overflow.

Reset
REQ-031 On rst_n low, SHALL set state to IDLE, head, tail and count to 0, and fetch pc to RESET_PC.
REQ-032 During reset, out_valid, fetch_req and count SHALL all be 0.
REQ-033 The first fetch_req SHALL be asserted in the first clk edge cycle after rst_n deasserts.
REQ-034 A reset during WAIT SHALL abandon the request, and a late fetch_valid SHALL be ignored under REQ-029.

Structure
REQ-035 A shared package SHALL hold the FSM state enum, INSN_W=32, FETCH_W=64, and the pc-increment constants 4 and 8.
REQ-036 There SHALL be one sub-module, fq_ram: DEPTH x 96-bit storage (instruction plus pc) with two write ports and ISSUE_W asynchronous read ports.

Verification
REQ-037 The bench SHALL cover: reset, RESET_PC=0, memory returning 64'h7C0802A6_38210010 one cycle after each request -> fetch_addr 0 then 1; out_insn slot0=7C0802A6 at pc 0, slot1=38210010 at pc 4.
REQ-038 The bench SHALL cover: DEPTH=4 with deq_count=0 held -> exactly 2 requests, count=4, then fetch_req stays low until a dequeue frees 2 slots.
REQ-039 The bench SHALL cover: flush with redirect_pc=64'h104 while WAIT -> the next response is dropped and count=0; the next fetch_addr is 0x20; only word [32:63] is pushed, at pc 0x104.
REQ-040 The bench SHALL cover: a push and deq_count=2 in the same cycle with count=2 -> count remains 2, and head and tail advance across the DEPTH wrap boundary correctly.
REQ-041 The bench SHALL cover: deq_count=2 with count=1 -> clamped, count=0, out_valid=0.
REQ-042 The bench SHALL cover: rst_n asserted mid-WAIT followed by a stray fetch_valid -> count remains 0 and the restart fetches from RESET_PC.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared types and constants for the instruction fetch queue
package fetch_queue_pkg;

  localparam int INSN_W = 32;
  localparam int FETCH_W = 64;
  localparam logic [63:0] PC_INC_ONE = 64'd4;
  localparam logic [63:0] PC_INC_TWO = 64'd8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DROP
  } fq_state_e;

  typedef struct packed {
    logic [63:0]       pc;
    logic [INSN_W-1:0] insn;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - memory-side and issue-side signals of the fetch queue
interface fetch_queue_if
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int ISSUE_W = 2
);

  logic                        flush;
  logic [63:0]                 redirect_pc;
  logic                        fetch_req;
  logic [60:0]                 fetch_addr;
  logic                        fetch_valid;
  logic [FETCH_W-1:0]          fetch_data;
  logic [ISSUE_W-1:0]          out_valid;
  logic [INSN_W*ISSUE_W-1:0]   out_insn;
  logic [64*ISSUE_W-1:0]       out_pc;
  logic [1:0]                  deq_count;
  logic [$clog2(DEPTH):0]      count;

  modport master (
    input  flush, redirect_pc, fetch_valid, fetch_data, deq_count,
    output fetch_req, fetch_addr, out_valid, out_insn, out_pc, count
  );

  modport slave (
    output flush, redirect_pc, fetch_valid, fetch_data, deq_count,
    input  fetch_req, fetch_addr, out_valid, out_insn, out_pc, count
  );

endinterface

// File: rtl/fq_ram.sv
// rtl/fq_ram.sv - queue entry storage, two write ports and ISSUE_W asynchronous read ports
module fq_ram
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int ISSUE_W = 2,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic                             clk_i,
  input  logic                             we0_i,
  input  logic [PTR_W-1:0]                 waddr0_i,
  input  fq_entry_t                        wdata0_i,
  input  logic                             we1_i,
  input  logic [PTR_W-1:0]                 waddr1_i,
  input  fq_entry_t                        wdata1_i,
  input  logic [ISSUE_W-1:0][PTR_W-1:0]    raddr_i,
  output fq_entry_t [ISSUE_W-1:0]          rdata_o
);

  fq_entry_t mem_q [DEPTH];

  // Contents need no reset: occupancy alone decides which entries are valid.
  always_ff @(posedge clk_i) begin
    if (we0_i) mem_q[waddr0_i] <= wdata0_i;
    if (we1_i) mem_q[waddr1_i] <= wdata1_i;
  end

  for (genvar i = 0; i < ISSUE_W; i++) begin : g_rd
    assign rdata_o[i] = mem_q[raddr_i[i]];
  end

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch queue: one outstanding doubleword fetch, circular buffer, flush/redirect
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 16,
  parameter int          ISSUE_W  = 2,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input logic           clk,
  input logic           rst_n,
  fetch_queue_if.master fq
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fq_state_e        state_q;
  logic             fetch_req_q;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [63:0]      pc_q, pc_d;

  logic [CNT_W-1:0] avail;
  logic [CNT_W-1:0] deq_req;
  logic [CNT_W-1:0] pop;
  logic [1:0]       push;
  logic             resp;
  logic             odd;
  logic             has_room;
  fq_entry_t        wdata0;
  fq_entry_t        wdata1;

  logic [ISSUE_W-1:0][PTR_W-1:0] raddr;
  fq_entry_t [ISSUE_W-1:0]       rdata;

  // Memory numbers bits MSB-first: data[0:31] is fetch_data[63:32], pc[61] is pc_q[2].
  always_comb begin
    avail       = (count_q < CNT_W'(ISSUE_W)) ? count_q : CNT_W'(ISSUE_W);
    deq_req     = CNT_W'(fq.deq_count);
    pop         = (deq_req > avail) ? avail : deq_req;
    resp        = (state_q == ST_WAIT) && fq.fetch_valid && !fq.flush;
    odd         = pc_q[2];
    push        = resp ? (odd ? 2'd1 : 2'd2) : 2'd0;
    has_room    = count_q <= CNT_W'(DEPTH - 2);

    wdata0.pc   = pc_q;
    wdata0.insn = odd ? fq.fetch_data[INSN_W-1:0] : fq.fetch_data[FETCH_W-1:INSN_W];
    wdata1.pc   = pc_q + PC_INC_ONE;
    wdata1.insn = fq.fetch_data[INSN_W-1:0];

    count_d = count_q + CNT_W'(push) - pop;
    head_d  = head_q + pop[PTR_W-1:0];
    tail_d  = tail_q + PTR_W'(push);
    pc_d    = resp ? (pc_q + (odd ? PC_INC_ONE : PC_INC_TWO)) : pc_q;
    if (fq.flush) begin
      count_d = '0;
      head_d  = tail_q;
      tail_d  = tail_q;
      pc_d    = fq.redirect_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      fetch_req_q <= 1'b0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      pc_q        <= RESET_PC;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      pc_q        <= pc_d;
      fetch_req_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!fq.flush && has_room) begin
            fetch_req_q <= 1'b1;
            state_q     <= ST_WAIT;
          end
        end
        // A response coinciding with a flush is already the outstanding one, so skip DROP.
        ST_WAIT: begin
          if (fq.fetch_valid)  state_q <= ST_IDLE;
          else if (fq.flush)   state_q <= ST_DROP;
        end
        ST_DROP: begin
          if (fq.fetch_valid)  state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  fq_ram #(
    .DEPTH   (DEPTH),
    .ISSUE_W (ISSUE_W)
  ) u_ram (
    .clk_i    (clk),
    .we0_i    (resp),
    .waddr0_i (tail_q),
    .wdata0_i (wdata0),
    .we1_i    (resp && !odd),
    .waddr1_i (tail_q + PTR_W'(1)),
    .wdata1_i (wdata1),
    .raddr_i  (raddr),
    .rdata_o  (rdata)
  );

  for (genvar i = 0; i < ISSUE_W; i++) begin : g_slot
    assign raddr[i]                         = head_q + PTR_W'(i);
    assign fq.out_valid[i]                  = count_q > CNT_W'(i);
    assign fq.out_insn[i*INSN_W +: INSN_W]  = rdata[i].insn;
    assign fq.out_pc[i*64 +: 64]            = rdata[i].pc;
  end

  assign fq.fetch_req  = fetch_req_q;
  assign fq.fetch_addr = pc_q[63:3];
  assign fq.count      = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue
module tb_fetch_queue;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  int   n_req;

  fetch_queue_if #(.DEPTH(4), .ISSUE_W(2)) fq ();

  fetch_queue #(
    .DEPTH    (4),
    .ISSUE_W  (2),
    .RESET_PC (64'h0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fq    (fq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (fq.fetch_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_req"}, 64'(fq.fetch_req), 64'd1);
  endtask

  task automatic respond(input logic [63:0] data);
    fq.fetch_data  = data;
    fq.fetch_valid = 1'b1;
    tick();
    fq.fetch_valid = 1'b0;
  endtask

  task automatic slot(input string tag, input int i, input logic [31:0] insn, input logic [63:0] pc);
    check({tag, "_insn"}, 64'(fq.out_insn[i*32 +: 32]), 64'(insn));
    check({tag, "_pc"}, fq.out_pc[i*64 +: 64], pc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    fq.flush = 1'b0;
    fq.redirect_pc = 64'h0;
    fq.fetch_valid = 1'b0;
    fq.fetch_data = 64'h0;
    fq.deq_count = 2'd0;
    tick();
    tick();
    check("rst_count", 64'(fq.count), 64'd0);
    check("rst_valid", 64'(fq.out_valid), 64'd0);
    check("rst_req", 64'(fq.fetch_req), 64'd0);

    // First request right after reset release, response one cycle later
    rst_n = 1'b1;
    tick();
    check("first_req", 64'(fq.fetch_req), 64'd1);
    check("first_addr", 64'(fq.fetch_addr), 64'd0);
    tick();
    check("one_req_only", 64'(fq.fetch_req), 64'd0);
    fq.fetch_data = 64'h7C0802A6_38210010;
    fq.fetch_valid = 1'b1;
    check("no_bypass", 64'(fq.out_valid), 64'd0);
    tick();
    fq.fetch_valid = 1'b0;
    check("push2_count", 64'(fq.count), 64'd2);
    check("push2_valid", 64'(fq.out_valid), 64'd3);
    slot("p1_s0", 0, 32'h7C0802A6, 64'h0);
    slot("p1_s1", 1, 32'h38210010, 64'h4);
    tick();
    check("second_req", 64'(fq.fetch_req), 64'd1);
    check("second_addr", 64'(fq.fetch_addr), 64'd1);
    tick();
    respond(64'h7C0802A6_38210010);
    check("full_count", 64'(fq.count), 64'd4);

    // Full: no further requests
    n_req = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (fq.fetch_req === 1'b1) n_req++;
    end
    check("full_noreq", 64'(n_req), 64'd0);
    check("full_count2", 64'(fq.count), 64'd4);

    fq.deq_count = 2'd1;
    tick();
    fq.deq_count = 2'd0;
    check("deq1_count", 64'(fq.count), 64'd3);
    slot("d1_s0", 0, 32'h38210010, 64'h4);
    slot("d1_s1", 1, 32'h7C0802A6, 64'h8);
    n_req = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (fq.fetch_req === 1'b1) n_req++;
    end
    check("free1_noreq", 64'(n_req), 64'd0);

    fq.deq_count = 2'd1;
    tick();
    fq.deq_count = 2'd0;
    check("deq2_count", 64'(fq.count), 64'd2);
    wait_req("free2");
    check("third_addr", 64'(fq.fetch_addr), 64'd2);

    // Push and dequeue of 2 in the same cycle, head wraps 2->0
    tick();
    fq.deq_count = 2'd2;
    slot("pre_wrap_s0", 0, 32'h7C0802A6, 64'h8);
    respond(64'hAAAA0001_BBBB0002);
    fq.deq_count = 2'd0;
    check("pushpop_count", 64'(fq.count), 64'd2);
    slot("wrap_s0", 0, 32'hAAAA0001, 64'h10);
    slot("wrap_s1", 1, 32'hBBBB0002, 64'h14);

    // Clamp: deq_count=2 with one valid entry
    fq.deq_count = 2'd1;
    tick();
    fq.deq_count = 2'd2;
    check("clamp_pre", 64'(fq.count), 64'd1);
    tick();
    fq.deq_count = 2'd0;
    check("clamp_count", 64'(fq.count), 64'd0);
    check("clamp_valid", 64'(fq.out_valid), 64'd0);

    // Flush while a request is outstanding
    fq.flush = 1'b1;
    fq.redirect_pc = 64'h104;
    tick();
    fq.flush = 1'b0;
    check("flush_count", 64'(fq.count), 64'd0);
    respond(64'hDEADBEEF_CAFEF00D);
    check("drop_count", 64'(fq.count), 64'd0);
    check("drop_valid", 64'(fq.out_valid), 64'd0);
    wait_req("redirect");
    check("redirect_addr", 64'(fq.fetch_addr), 64'h20);
    tick();
    respond(64'h12345678_9ABCDEF0);
    check("odd_count", 64'(fq.count), 64'd1);
    check("odd_valid", 64'(fq.out_valid), 64'd1);
    slot("odd_s0", 0, 32'h9ABCDEF0, 64'h104);

    // Reset during WAIT, then a stray response
    wait_req("pre_rst");
    check("pre_rst_addr", 64'(fq.fetch_addr), 64'h21);
    rst_n = 1'b0;
    #1;
    check("async_rst_count", 64'(fq.count), 64'd0);
    check("async_rst_req", 64'(fq.fetch_req), 64'd0);
    tick();
    rst_n = 1'b1;
    fq.fetch_data = 64'hFFFFFFFF_FFFFFFFF;
    fq.fetch_valid = 1'b1;
    tick();
    fq.fetch_valid = 1'b0;
    check("stray_count", 64'(fq.count), 64'd0);
    check("restart_req", 64'(fq.fetch_req), 64'd1);
    check("restart_addr", 64'(fq.fetch_addr), 64'd0);
    tick();
    respond(64'h7C0802A6_38210010);
    check("restart_count", 64'(fq.count), 64'd2);
    slot("restart_s0", 0, 32'h7C0802A6, 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
